spi_slave: RTL and testbench
============================

// Module: spi_slave
// PURPOSE
//  SPI responder (mode 0, MSB first, 8- or 16-bit words) clocked by raw_clk.
//  Oversamples externally driven sclk/cs_n/mosi, assembles received words and
//  shifts out a preloaded reply on miso. Lets a micro86 core act as a peripheral
//  on a bus driven by an SPI master (including the team's own spi master block).
// PARAMETERS
//  SYNC_STAGES  2  flip-flop stages on sclk, cs_n, mosi (min 2)
// PORTS
//  raw_clk    in   1   system clock; all logic on posedge
//  reset      in   1   synchronous, active-high reset
//  width_16   in   1   0 = 8-bit words, 1 = 16-bit; sampled at cs_n assert
//  data_tx    in   16  reply word; 8-bit mode uses data_tx[7:0]
//  tx_load    in   1   1-cycle strobe: capture data_tx into tx holding reg
//  tx_ready   out  1   1 = holding reg empty, tx_load accepted
//  data_rx    out  16  last complete word; 8-bit mode zero-extends into [15:8]
//  rx_valid   out  1   1 = data_rx unread; cleared by rx_ack
//  rx_ack     in   1   1-cycle strobe: consume data_rx
//  overrun    out  1   sticky: word completed while rx_valid=1; clears on reset
//  busy       out  1   1 = transfer in progress (state != IDLE)
//  cs_n       in   1   chip select from master, active low (async)
//  sclk       in   1   SPI clock from master (async), idle low
//  mosi       in   1   data from master (async)
//  miso       out  1   data to master
// BEHAVIOUR
//  - Reset: state=IDLE, tx_ready=1, rx_valid=0, overrun=0, data_rx=0, miso=0,
//    busy=0, bit count=0, sync chains cleared to idle (cs_n=1, sclk=0).
//  - Timing: sclk high and low phases each >= SYNC_STAGES+2 raw_clk cycles;
//    edges are detected on synchronized sclk (prev/cur compare).
//  - States: IDLE, SHIFT, DONE.
//  - IDLE: synced cs_n falls -> latch width_16; load tx shift reg from holding
//    reg (8-bit: data_tx[7:0] into [15:8]) or 0 if tx_ready=1; set tx_ready=1;
//    miso <= shift[15] in the same cycle; count=0; -> SHIFT.
//  - SHIFT, sclk rising: rx_shift <= {rx_shift[14:0], mosi_sync}; count+1.
//  - SHIFT, sclk falling: tx shift left one, miso <= new shift[15].
//  - Count reaches 8 (width_16=0) or 16 (width_16=1) on a rising edge -> DONE.
//  - DONE (1 cycle): data_rx <= rx_shift (8-bit: {8'h00, rx_shift[7:0]});
//    if rx_valid already 1, set overrun and still overwrite data_rx;
//    rx_valid <= 1; -> SHIFT with count=0, reloading tx shift reg as in IDLE
//    (back-to-back words under one cs_n). miso updates on the next sclk fall.
//  - Latency: rx_valid rises 2 raw_clk cycles after the synced final sclk rise.
//  - Synced cs_n rises in SHIFT with count != 0: abort; partial word discarded;
//    no rx_valid; -> IDLE; miso <= 0. cs_n rise in DONE: DONE completes, then IDLE.
//  - rx_ack and a DONE write in the same cycle: the write wins, so rx_valid
//    stays 1 and overrun is not set.
//  - tx_load with tx_ready=0: ignored. tx_load in the same cycle as a reload:
//    the reload takes the old contents, then the new word is captured.
//  - sclk edges while cs_n is high are ignored. width_16 changes mid-word have
//    no effect.
//  - reset mid-transfer: immediate return to reset values; the next word starts
//    only on a fresh cs_n falling edge.
// STRUCTURE
//  - Shared package/include: state encodings (STATE_IDLE=0, STATE_SHIFT=1,
//    STATE_DONE=2), WORD_8=8, WORD_16=16.
//  - One sub-module: spi_sync_edge (SYNC_STAGES-deep synchronizer with
//    rise/fall pulse outputs), instanced for sclk and cs_n; mosi uses the
//    synchronizer only.
// TESTING
//  - 8-bit: tx_load 16'h00A5, master sends 8'h3C -> miso bits 1010_0101,
//    data_rx=16'h003C, rx_valid=1, overrun=0.
//  - 16-bit: width_16=1, tx_load 16'hBEEF, master sends 16'h1234 -> miso
//    shifts out BEEF MSB first, data_rx=16'h1234.
//  - Back-to-back 8'h11, 8'h22 under one cs_n, no rx_ack -> data_rx=16'h0022,
//    overrun=1.
//  - No tx_load before transfer -> miso=0 for all bits, tx_ready stays 1.
//  - cs_n deasserted after 5 sclk -> rx_valid stays 0, busy=0, next full
//    word 8'h5A received correctly.
//  - reset asserted at bit 3 -> all outputs at reset values next cycle;
//    a following transfer of 8'hC3 completes correctly.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI responder.
//   state_t       : FSM encoding (IDLE / SHIFT / DONE)
//   WORD_8/16     : supported word lengths in bits
//   reload_word() : value the tx shift register takes when a word starts
package spi_slave_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE  = 2'd0,
        STATE_SHIFT = 2'd1,
        STATE_DONE  = 2'd2
    } state_t;

    localparam int WORD_8  = 8;
    localparam int WORD_16 = 16;

    // An empty holding register sends zeros. In 8-bit mode the low byte is
    // left-justified so that miso always comes from bit 15.
    function automatic logic [15:0] reload_word(input logic [15:0] hold,
                                                input logic        empty,
                                                input logic        w16);
        if (empty)
            return 16'h0000;
        return w16 ? hold : {hold[7:0], 8'h00};
    endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Bus interface of the SPI responder: host-side word handshake plus the
// raw SPI pins. Signal prefixes are from the responder's point of view.
//   slave  : modport used by spi_slave
//   master : modport for whatever drives the responder (host + SPI master)
interface spi_slave_if;

    logic        i_width_16;
    logic [15:0] i_data_tx;
    logic        i_tx_load;
    logic        o_tx_ready;
    logic [15:0] o_data_rx;
    logic        o_rx_valid;
    logic        i_rx_ack;
    logic        o_overrun;
    logic        o_busy;
    logic        i_cs_n;
    logic        i_sclk;
    logic        i_mosi;
    logic        o_miso;

    modport slave (
        input  i_width_16, i_data_tx, i_tx_load, i_rx_ack, i_cs_n, i_sclk, i_mosi,
        output o_tx_ready, o_data_rx, o_rx_valid, o_overrun, o_busy, o_miso
    );

    modport master (
        output i_width_16, i_data_tx, i_tx_load, i_rx_ack, i_cs_n, i_sclk, i_mosi,
        input  o_tx_ready, o_data_rx, o_rx_valid, o_overrun, o_busy, o_miso
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for an asynchronous input with single-cycle
// rise/fall pulses derived from the synchronized level.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_async        : asynchronous input
//   o_sync         : synchronized level
//   o_rise, o_fall : one-cycle pulses on synchronized edges
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_chain;
    logic                   r_prev;

    // Reset to the line's idle level so no phantom edge appears afterwards.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_chain <= {SYNC_STAGES{RST_VAL}};
            r_prev  <= RST_VAL;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
            r_prev  <= r_chain[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_chain[SYNC_STAGES-1];
    assign o_rise = o_sync & ~r_prev;
    assign o_fall = ~o_sync & r_prev;

endmodule

// File: rtl/spi_slave.sv
// SPI responder, mode 0, MSB first, 8- or 16-bit words, oversampled on
// i_raw_clk. Receives words from mosi into o_data_rx and shifts a preloaded
// reply out on miso; consecutive words may share one chip-select.
//   i_raw_clk : system clock
//   i_reset   : synchronous active-high reset
//   bus       : spi_slave_if.slave (host handshake + SPI pins)
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_raw_clk,
    input  logic        i_reset,
    spi_slave_if.slave  bus
);

    logic w_sclk_rise, w_sclk_fall, w_sclk_sync;
    logic w_cs_fall, w_cs_rise, w_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_chain;
    logic w_mosi_sync;

    state_t      r_state, w_state_nxt;
    logic        w_start, w_reload;
    logic [15:0] w_reload_word;
    logic [4:0]  w_target;

    logic        r_w16;
    logic [4:0]  r_count;
    logic [15:0] r_tx_hold;
    logic        r_tx_ready;
    logic [15:0] r_tx_shift;
    logic [15:0] r_rx_shift;
    logic [15:0] r_data_rx;
    logic        r_rx_valid;
    logic        r_overrun;
    logic        r_miso;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .i_clk   (i_raw_clk),
        .i_reset (i_reset),
        .i_async (bus.i_sclk),
        .o_sync  (w_sclk_sync),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .i_clk   (i_raw_clk),
        .i_reset (i_reset),
        .i_async (bus.i_cs_n),
        .o_sync  (w_cs_sync),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    // mosi needs no edge detect; same depth as sclk keeps them aligned.
    always_ff @(posedge i_raw_clk) begin
        if (i_reset)
            r_mosi_chain <= '0;
        else
            r_mosi_chain <= {r_mosi_chain[SYNC_STAGES-2:0], bus.i_mosi};
    end
    assign w_mosi_sync = r_mosi_chain[SYNC_STAGES-1];

    assign w_target      = r_w16 ? 5'(WORD_16) : 5'(WORD_8);
    // In IDLE the word width is being latched this cycle, so use the input.
    assign w_reload_word = reload_word(r_tx_hold, r_tx_ready,
                                       (r_state == STATE_IDLE) ? bus.i_width_16 : r_w16);

    always_ff @(posedge i_raw_clk) begin
        if (i_reset)
            r_state <= STATE_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Chip-select level (not just its rising pulse) ends a transfer, so a
    // release that lands during DONE is still honoured once DONE finishes.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_reload    = 1'b0;
        case (r_state)
            STATE_IDLE: begin
                if (w_cs_fall) begin
                    w_start     = 1'b1;
                    w_reload    = 1'b1;
                    w_state_nxt = STATE_SHIFT;
                end
            end
            STATE_SHIFT: begin
                if (w_cs_sync)
                    w_state_nxt = STATE_IDLE;
                else if (w_sclk_rise && (r_count + 5'd1 == w_target))
                    w_state_nxt = STATE_DONE;
            end
            STATE_DONE: begin
                if (w_cs_sync) begin
                    w_state_nxt = STATE_IDLE;
                end else begin
                    w_reload    = 1'b1;
                    w_state_nxt = STATE_SHIFT;
                end
            end
            default: w_state_nxt = STATE_IDLE;
        endcase
    end

    always_ff @(posedge i_raw_clk) begin
        if (i_reset) begin
            r_w16      <= 1'b0;
            r_count    <= '0;
            r_tx_hold  <= '0;
            r_tx_ready <= 1'b1;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_data_rx  <= '0;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
            r_miso     <= 1'b0;
        end else begin
            // A reload consumes the holding register; a same-cycle load
            // (accepted only if it was already empty) refills it afterwards.
            if (w_reload)
                r_tx_ready <= 1'b1;
            if (bus.i_tx_load && r_tx_ready) begin
                r_tx_hold  <= bus.i_data_tx;
                r_tx_ready <= 1'b0;
            end

            if (bus.i_rx_ack)
                r_rx_valid <= 1'b0;

            case (r_state)
                STATE_IDLE: begin
                    if (w_start) begin
                        r_w16      <= bus.i_width_16;
                        r_tx_shift <= w_reload_word;
                        r_miso     <= w_reload_word[15];
                        r_count    <= '0;
                    end
                end
                STATE_SHIFT: begin
                    if (w_cs_sync) begin
                        r_miso  <= 1'b0;
                        r_count <= '0;
                    end else begin
                        if (w_sclk_rise) begin
                            r_rx_shift <= {r_rx_shift[14:0], w_mosi_sync};
                            r_count    <= r_count + 5'd1;
                        end
                        // count==0 here means a word was just reloaded: the
                        // trailing fall of the previous word presents the new
                        // MSB instead of shifting it away.
                        if (w_sclk_fall) begin
                            if (r_count == 5'd0) begin
                                r_miso <= r_tx_shift[15];
                            end else begin
                                r_tx_shift <= {r_tx_shift[14:0], 1'b0};
                                r_miso     <= r_tx_shift[14];
                            end
                        end
                    end
                end
                STATE_DONE: begin
                    r_data_rx  <= r_w16 ? r_rx_shift : {8'h00, r_rx_shift[7:0]};
                    if (r_rx_valid && !bus.i_rx_ack)
                        r_overrun <= 1'b1;
                    r_rx_valid <= 1'b1;
                    r_count    <= '0;
                    if (w_cs_sync)
                        r_miso <= 1'b0;
                    else
                        r_tx_shift <= w_reload_word;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_tx_ready = r_tx_ready;
    assign bus.o_data_rx  = r_data_rx;
    assign bus.o_rx_valid = r_rx_valid;
    assign bus.o_overrun  = r_overrun;
    assign bus.o_busy     = (r_state != STATE_IDLE);
    assign bus.o_miso     = r_miso;

    // Edge pulses of cs_n rising and the synced sclk level are not needed:
    // transfer end uses the cs_n level, shifting uses the sclk edges.
    logic w_unused;
    assign w_unused = w_cs_rise ^ w_sclk_sync;

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

    localparam int HP = 6;  // sclk half period in raw_clk cycles

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    spi_slave_if bus();

    spi_slave #(.SYNC_STAGES(2)) dut (
        .i_raw_clk (clk),
        .i_reset   (reset),
        .bus       (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        w16;
        logic [15:0] load;
        logic        do_load;
        logic [15:0] load2;
        logic        do_load2;
        logic [15:0] mosi_w;
        logic [15:0] exp_miso;
        logic [15:0] exp_rx;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [15:0] w);
        bus.i_data_tx = w;
        bus.i_tx_load = 1'b1;
        cyc(1);
        bus.i_tx_load = 1'b0;
    endtask

    task automatic ack();
        bus.i_rx_ack = 1'b1;
        cyc(1);
        bus.i_rx_ack = 1'b0;
        cyc(1);
    endtask

    task automatic cs_assert();
        bus.i_cs_n = 1'b0;
        cyc(HP);
    endtask

    task automatic cs_deassert();
        cyc(HP);
        bus.i_cs_n = 1'b1;
        cyc(2 * HP);
    endtask

    // Mode 0 master: mosi changes with sclk low, miso sampled as sclk rises.
    task automatic send_bits(input logic [15:0] w, input int nbits, output logic [15:0] mb);
        mb = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            bus.i_mosi = w[i];
            cyc(HP);
            bus.i_sclk = 1'b1;
            mb[i] = bus.o_miso;
            cyc(HP);
            bus.i_sclk = 1'b0;
        end
    endtask

    initial begin
        logic [15:0] mb, mb2;
        vec_t v;
        int nb;

        //          w16   load     ld    load2    ld2   mosi     miso     rx
        vecs[0] = '{1'b0, 16'h00A5, 1'b1, 16'h0000, 1'b0, 16'h003C, 16'h00A5, 16'h003C};
        vecs[1] = '{1'b1, 16'hBEEF, 1'b1, 16'h0000, 1'b0, 16'h1234, 16'hBEEF, 16'h1234};
        vecs[2] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h00FF, 16'h0000, 16'h00FF};
        vecs[3] = '{1'b0, 16'h7E81, 1'b1, 16'hFFFF, 1'b1, 16'h0080, 16'h0081, 16'h0080};
        vecs[4] = '{1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h8001, 16'h0000, 16'h8001};
        vecs[5] = '{1'b1, 16'h0001, 1'b1, 16'h0000, 1'b0, 16'hFFFF, 16'h0001, 16'hFFFF};

        bus.i_cs_n = 1'b1;
        bus.i_sclk = 1'b0;
        bus.i_mosi = 1'b0;
        bus.i_width_16 = 1'b0;
        bus.i_data_tx = '0;
        bus.i_tx_load = 1'b0;
        bus.i_rx_ack = 1'b0;
        cyc(3);
        chk("rst tx_ready", bus.o_tx_ready, 1'b1);
        chk("rst rx_valid", bus.o_rx_valid, 1'b0);
        chk("rst overrun", bus.o_overrun, 1'b0);
        chk("rst data_rx", bus.o_data_rx, 16'h0000);
        chk("rst miso", bus.o_miso, 1'b0);
        chk("rst busy", bus.o_busy, 1'b0);
        reset = 1'b0;
        cyc(2);

        for (int k = 0; k < 6; k++) begin
            v = vecs[k];
            nb = v.w16 ? 16 : 8;
            bus.i_width_16 = v.w16;
            if (v.do_load) begin
                load(v.load);
                chk($sformatf("v%0d tx_ready after load", k), bus.o_tx_ready, 1'b0);
            end
            if (v.do_load2) load(v.load2);
            cs_assert();
            chk($sformatf("v%0d busy", k), bus.o_busy, 1'b1);
            chk($sformatf("v%0d tx_ready after start", k), bus.o_tx_ready, 1'b1);
            bus.i_width_16 = ~v.w16;  // must not affect the word in flight
            send_bits(v.mosi_w, nb, mb);
            cs_deassert();
            chk($sformatf("v%0d miso bits", k), mb, v.exp_miso);
            chk($sformatf("v%0d data_rx", k), bus.o_data_rx, v.exp_rx);
            chk($sformatf("v%0d rx_valid", k), bus.o_rx_valid, 1'b1);
            chk($sformatf("v%0d overrun", k), bus.o_overrun, 1'b0);
            chk($sformatf("v%0d busy end", k), bus.o_busy, 1'b0);
            chk($sformatf("v%0d miso idle", k), bus.o_miso, 1'b0);
            ack();
            chk($sformatf("v%0d rx_valid after ack", k), bus.o_rx_valid, 1'b0);
        end

        // Abort after 5 clocks, then stray sclk with cs_n high, then a full word.
        bus.i_width_16 = 1'b0;
        cs_assert();
        send_bits(16'h001F, 5, mb);
        cs_deassert();
        chk("abort rx_valid", bus.o_rx_valid, 1'b0);
        chk("abort busy", bus.o_busy, 1'b0);
        for (int i = 0; i < 3; i++) begin
            bus.i_sclk = 1'b1; cyc(HP);
            bus.i_sclk = 1'b0; cyc(HP);
        end
        chk("idle sclk busy", bus.o_busy, 1'b0);
        chk("idle sclk rx_valid", bus.o_rx_valid, 1'b0);
        cs_assert();
        send_bits(16'h005A, 8, mb);
        cs_deassert();
        chk("after abort data_rx", bus.o_data_rx, 16'h005A);
        chk("after abort rx_valid", bus.o_rx_valid, 1'b1);
        ack();

        // Back-to-back words under one cs_n, no ack; second reply loaded mid-word.
        load(16'h0096);
        cs_assert();
        load(16'h003C);
        send_bits(16'h0011, 8, mb);
        send_bits(16'h0022, 8, mb2);
        cs_deassert();
        chk("b2b miso w1", mb, 16'h0096);
        chk("b2b miso w2", mb2, 16'h003C);
        chk("b2b data_rx", bus.o_data_rx, 16'h0022);
        chk("b2b rx_valid", bus.o_rx_valid, 1'b1);
        chk("b2b overrun", bus.o_overrun, 1'b1);

        // Reset at bit 3 while rx_valid/overrun are set and miso is high.
        load(16'h00FF);
        cs_assert();
        send_bits(16'h0005, 3, mb);
        chk("pre-reset miso", bus.o_miso, 1'b1);
        chk("pre-reset busy", bus.o_busy, 1'b1);
        reset = 1'b1;
        bus.i_cs_n = 1'b1;
        cyc(1);
        chk("mid rst busy", bus.o_busy, 1'b0);
        chk("mid rst miso", bus.o_miso, 1'b0);
        chk("mid rst rx_valid", bus.o_rx_valid, 1'b0);
        chk("mid rst overrun", bus.o_overrun, 1'b0);
        chk("mid rst data_rx", bus.o_data_rx, 16'h0000);
        chk("mid rst tx_ready", bus.o_tx_ready, 1'b1);
        reset = 1'b0;
        cyc(4);
        load(16'h005A);
        cs_assert();
        send_bits(16'h00C3, 8, mb);
        cs_deassert();
        chk("post rst miso", mb, 16'h005A);
        chk("post rst data_rx", bus.o_data_rx, 16'h00C3);
        chk("post rst rx_valid", bus.o_rx_valid, 1'b1);
        chk("post rst overrun", bus.o_overrun, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
